// File: rtl/sa_pkg.sv
// Shared types and helpers for the output-stationary systolic matrix-multiply engine.
package sa_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Wide enough that a single N-term dot product of W-bit operands never wraps.
    function automatic int acc_width(input int w, input int n);
        return 2 * w + $clog2(n);
    endfunction

    function automatic int elem_lo(input int r, input int c, input int n, input int w);
        return (r * n + c) * w;
    endfunction

endpackage

// File: rtl/sa_matmul_engine_if.sv
// Operand, control and result bundle between a host and the systolic engine.
interface sa_matmul_engine_if
    import sa_pkg::*;
#(
    parameter int W     = 16,
    parameter int N     = 3,
    parameter int ACC_W = acc_width(W, N)
);
    logic                   i_en;
    logic                   i_mode;
    logic                   i_start;
    logic                   i_clr;
    logic [W*N*N-1:0]       i_A;
    logic [W*N*N-1:0]       i_B;
    logic [ACC_W*N*N-1:0]   o_C;
    logic                   o_busy;
    logic                   o_done;
    logic                   o_ovf;

    modport master (
        output i_en, i_mode, i_start, i_clr, i_A, i_B,
        input  o_C, o_busy, o_done, o_ovf
    );

    modport slave (
        input  i_en, i_mode, i_start, i_clr, i_A, i_B,
        output o_C, o_busy, o_done, o_ovf
    );
endinterface

// File: rtl/sa_pe.sv
// One processing element: multiply-accumulate with registered pass-through of a and b.
module sa_pe
    import sa_pkg::*;
#(
    parameter int W     = 16,
    parameter int ACC_W = 2 * W + 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             clr_ab_i,
    input  logic             clr_acc_i,
    input  logic             clr_ovf_i,
    input  logic [W-1:0]     a_i,
    input  logic [W-1:0]     b_i,
    output logic [W-1:0]     a_o,
    output logic [W-1:0]     b_o,
    output logic [ACC_W-1:0] acc_o,
    output logic             ovf_o
);
    logic [W-1:0]     a_q, b_q;
    logic [ACC_W-1:0] acc_q;
    logic             ovf_q;
    logic [2*W-1:0]   prod;
    logic [ACC_W:0]   sum;

    assign prod = {{W{1'b0}}, a_i} * {{W{1'b0}}, b_i};
    // The extra top bit of sum is the carry out of the ACC_W-bit add.
    assign sum  = {1'b0, acc_q} + {{(ACC_W + 1 - 2 * W){1'b0}}, prod};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            if (clr_ab_i) begin
                a_q <= '0;
                b_q <= '0;
            end else if (en_i) begin
                a_q <= a_i;
                b_q <= b_i;
            end
            if (clr_acc_i)   acc_q <= '0;
            else if (en_i)   acc_q <= sum[ACC_W-1:0];
            if (clr_ovf_i)              ovf_q <= 1'b0;
            else if (en_i && sum[ACC_W]) ovf_q <= 1'b1;
        end
    end

    assign a_o   = a_q;
    assign b_o   = b_q;
    assign acc_o = acc_q;
    assign ovf_o = ovf_q;
endmodule

// File: rtl/sa_matmul_engine.sv
// N x N output-stationary systolic engine: control FSM, operand latches, skew feeders and PE grid.
module sa_matmul_engine
    import sa_pkg::*;
#(
    parameter int W     = 16,
    parameter int N     = 3,
    parameter int ACC_W = acc_width(W, N)
) (
    input  logic               i_clk,
    input  logic               i_rst,
    sa_matmul_engine_if.slave  bus
);
    localparam int LAST_T = 3 * N - 3;
    localparam int CNT_W  = $clog2(3 * N);

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [W*N*N-1:0]       a_lat_q, b_lat_q;
    logic [ACC_W*N*N-1:0]   c_q, c_d;
    logic                   done_q, done_d;
    logic                   idle_en, go_clr, go_start, pe_en, clr_acc, clr_ovf;
    int                     t;

    logic [W-1:0]     row_in [N];
    logic [W-1:0]     col_in [N];
    logic [W-1:0]     a_w    [N][N];
    logic [W-1:0]     b_w    [N][N];
    logic [ACC_W-1:0] acc_w  [N][N];
    logic [N*N-1:0]   ovf_w;

    assign idle_en  = bus.i_en && (state_q == ST_IDLE);
    assign go_clr   = idle_en && bus.i_clr;
    assign go_start = idle_en && !bus.i_clr && bus.i_start;
    assign pe_en    = bus.i_en && (state_q == ST_RUN);
    assign clr_acc  = go_clr || (go_start && !bus.i_mode);
    assign clr_ovf  = go_clr || go_start;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)         state_q <= ST_IDLE;
        else if (bus.i_en) state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (bus.i_start && !bus.i_clr) state_d = ST_RUN;
            ST_RUN:  if (cnt_q == CNT_W'(LAST_T))   state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.o_busy = (state_q != ST_IDLE);
    end

    always_comb begin
        cnt_d = cnt_q;
        if (go_start)   cnt_d = '0;
        else if (pe_en) cnt_d = cnt_q + 1'b1;
        done_d = bus.i_en ? (state_q == ST_DONE) : done_q;
        c_d = c_q;
        if (go_clr) begin
            c_d = '0;
        end else if (bus.i_en && (state_q == ST_DONE)) begin
            for (int r = 0; r < N; r++)
                for (int c = 0; c < N; c++)
                    c_d[elem_lo(r, c, N, ACC_W) +: ACC_W] = acc_w[r][c];
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_q   <= '0;
            done_q  <= 1'b0;
            c_q     <= '0;
            a_lat_q <= '0;
            b_lat_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            done_q <= done_d;
            c_q    <= c_d;
            if (go_start) begin
                a_lat_q <= bus.i_A;
                b_lat_q <= bus.i_B;
            end
        end
    end

    // Skew: row i starts i cycles late, column j starts j cycles late.
    assign t = 32'(cnt_q);
    always_comb begin
        for (int i = 0; i < N; i++) begin
            row_in[i] = '0;
            col_in[i] = '0;
            if (t >= i && t - i < N) begin
                row_in[i] = a_lat_q[elem_lo(i, t - i, N, W) +: W];
                col_in[i] = b_lat_q[elem_lo(t - i, i, N, W) +: W];
            end
        end
    end

    for (genvar r = 0; r < N; r++) begin : g_row
        for (genvar c = 0; c < N; c++) begin : g_col
            logic [W-1:0] a_in, b_in;
            if (c == 0) begin : g_afeed
                assign a_in = row_in[r];
            end else begin : g_achain
                assign a_in = a_w[r][c-1];
            end
            if (r == 0) begin : g_bfeed
                assign b_in = col_in[c];
            end else begin : g_bchain
                assign b_in = b_w[r-1][c];
            end
            sa_pe #(.W(W), .ACC_W(ACC_W)) u_pe (
                .clk_i     (i_clk),
                .rst_i     (i_rst),
                .en_i      (pe_en),
                .clr_ab_i  (go_start),
                .clr_acc_i (clr_acc),
                .clr_ovf_i (clr_ovf),
                .a_i       (a_in),
                .b_i       (b_in),
                .a_o       (a_w[r][c]),
                .b_o       (b_w[r][c]),
                .acc_o     (acc_w[r][c]),
                .ovf_o     (ovf_w[r*N+c])
            );
        end
    end

    assign bus.o_C    = c_q;
    assign bus.o_done = done_q;
    assign bus.o_ovf  = |ovf_w;
endmodule

// File: tb/tb_sa_matmul_engine.sv
// Directed bench for sa_matmul_engine at W=16, N=3 with hand-computed results.
module tb_sa_matmul_engine;
    localparam int W     = 16;
    localparam int N     = 3;
    localparam int ACC_W = 34;
    localparam int NE    = N * N;

    logic clk = 1'b0;
    logic rst;
    int   vectors = 0;
    int   miscompares = 0;
    logic [ACC_W-1:0] exp_c [NE];

    always #5 clk = ~clk;

    sa_matmul_engine_if #(.W(W), .N(N), .ACC_W(ACC_W)) bus ();

    sa_matmul_engine #(.W(W), .N(N), .ACC_W(ACC_W)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    function automatic logic [W*NE-1:0] fill(input logic [W-1:0] v);
        logic [W*NE-1:0] m;
        for (int e = 0; e < NE; e++) m[e*W +: W] = v;
        return m;
    endfunction

    function automatic logic [W*NE-1:0] ident();
        logic [W*NE-1:0] m;
        for (int e = 0; e < NE; e++) m[e*W +: W] = (e % (N + 1) == 0) ? 16'd1 : 16'd0;
        return m;
    endfunction

    function automatic logic [W*NE-1:0] seq1();
        logic [W*NE-1:0] m;
        for (int e = 0; e < NE; e++) m[e*W +: W] = W'(e + 1);
        return m;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues start for one edge (E0); afterwards inputs are scrambled to show they are not needed.
    task automatic start_job(input logic mode);
        bus.i_mode  = mode;
        bus.i_start = 1'b1;
        tick();
        bus.i_start = 1'b0;
        bus.i_mode  = ~mode;
        bus.i_A     = fill(16'h1234);
        bus.i_B     = fill(16'h4321);
    endtask

    task automatic wait_done(output int k);
        k = -1;
        for (int n = 1; n <= 60; n++) begin
            tick();
            if (bus.o_done === 1'b1) begin
                k = n;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.i_en = 1'b1; bus.i_mode = 1'b0; bus.i_start = 1'b0; bus.i_clr = 1'b0;
        bus.i_A = '0; bus.i_B = '0;
        tick(); tick();
        vectors++;
        if (bus.o_busy !== 1'b0 || bus.o_done !== 1'b0 || bus.o_ovf !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_flags busy=%b done=%b ovf=%b want 000", bus.o_busy, bus.o_done, bus.o_ovf);
        end
        vectors++;
        if (bus.o_C !== '0) begin
            miscompares++;
            $display("FAIL reset_C got %h want 0", bus.o_C);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_overwrite();
        int k;
        bus.i_A = fill(16'h0f0f); bus.i_B = fill(16'h0f0f);
        start_job(1'b0);
        vectors++;
        if (bus.o_busy !== 1'b1) begin
            miscompares++;
            $display("FAIL ovw_busy got %b want 1", bus.o_busy);
        end
        wait_done(k);
        vectors++;
        if (k != 8) begin
            miscompares++;
            $display("FAIL ovw_latency got %0d want 8", k);
        end
        for (int e = 0; e < NE; e++) begin
            vectors++;
            if (bus.o_C[e*ACC_W +: ACC_W] !== 34'h02A848A3) begin
                miscompares++;
                $display("FAIL ovw_C[%0d] got %h want 02a848a3", e, bus.o_C[e*ACC_W +: ACC_W]);
            end
        end
        vectors++;
        if (bus.o_ovf !== 1'b0) begin
            miscompares++;
            $display("FAIL ovw_ovf got %b want 0", bus.o_ovf);
        end
        tick();
        vectors++;
        if (bus.o_done !== 1'b0 || bus.o_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL ovw_pulse done=%b busy=%b want 0 0", bus.o_done, bus.o_busy);
        end
    endtask

    task automatic test_identity();
        int k;
        for (int pass = 0; pass < 2; pass++) begin
            bus.i_A = ident(); bus.i_B = seq1();
            for (int e = 0; e < NE; e++) exp_c[e] = ACC_W'((e + 1) * (pass + 1));
            start_job(pass[0]);
            wait_done(k);
            vectors++;
            if (k != 8) begin
                miscompares++;
                $display("FAIL ident%0d_latency got %0d want 8", pass, k);
            end
            for (int e = 0; e < NE; e++) begin
                vectors++;
                if (bus.o_C[e*ACC_W +: ACC_W] !== exp_c[e]) begin
                    miscompares++;
                    $display("FAIL ident%0d_C[%0d] got %0d want %0d", pass, e, bus.o_C[e*ACC_W +: ACC_W], exp_c[e]);
                end
            end
            tick();
        end
    endtask

    task automatic test_overflow();
        int k;
        for (int pass = 0; pass < 2; pass++) begin
            bus.i_A = fill(16'hFFFF); bus.i_B = fill(16'hFFFF);
            start_job(pass[0]);
            wait_done(k);
            vectors++;
            if (k != 8) begin
                miscompares++;
                $display("FAIL ovf%0d_latency got %0d want 8", pass, k);
            end
            for (int e = 0; e < NE; e++) begin
                vectors++;
                if (bus.o_C[e*ACC_W +: ACC_W] !== ((pass == 0) ? 34'h2FFFA0003 : 34'h1FFF40006)) begin
                    miscompares++;
                    $display("FAIL ovf%0d_C[%0d] got %h", pass, e, bus.o_C[e*ACC_W +: ACC_W]);
                end
            end
            vectors++;
            if (bus.o_ovf !== pass[0]) begin
                miscompares++;
                $display("FAIL ovf%0d_flag got %b want %b", pass, bus.o_ovf, pass[0]);
            end
            tick();
        end
    endtask

    task automatic test_stall();
        int k = -1;
        int extra = 0;
        bus.i_A = fill(16'h0f0f); bus.i_B = fill(16'h0f0f);
        start_job(1'b0);
        for (int n = 1; n <= 60; n++) begin
            tick();
            if (bus.o_done === 1'b1) begin
                k = n;
                break;
            end
            if (n == 1) bus.i_start = 1'b1;
            if (n == 2) bus.i_start = 1'b0;
            if (n == 3) bus.i_en = 1'b0;
            if (n == 7) bus.i_en = 1'b1;
        end
        bus.i_en = 1'b1; bus.i_start = 1'b0;
        vectors++;
        if (k != 12) begin
            miscompares++;
            $display("FAIL stall_latency got %0d want 12", k);
        end
        for (int e = 0; e < NE; e++) begin
            vectors++;
            if (bus.o_C[e*ACC_W +: ACC_W] !== 34'h02A848A3) begin
                miscompares++;
                $display("FAIL stall_C[%0d] got %h want 02a848a3", e, bus.o_C[e*ACC_W +: ACC_W]);
            end
        end
        vectors++;
        if (bus.o_ovf !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_ovf got %b want 0", bus.o_ovf);
        end
        for (int n = 0; n < 15; n++) begin
            tick();
            if (bus.o_done === 1'b1) extra++;
        end
        vectors++;
        if (extra != 0) begin
            miscompares++;
            $display("FAIL stall_extra_done got %0d want 0", extra);
        end
    endtask

    task automatic test_clr_start();
        bus.i_clr = 1'b1; bus.i_start = 1'b1; bus.i_mode = 1'b0;
        tick();
        bus.i_clr = 1'b0; bus.i_start = 1'b0;
        for (int n = 0; n < 3; n++) begin
            vectors++;
            if (bus.o_busy !== 1'b0 || bus.o_done !== 1'b0 || bus.o_C !== '0) begin
                miscompares++;
                $display("FAIL clr_start[%0d] busy=%b done=%b C=%h want 0 0 0", n, bus.o_busy, bus.o_done, bus.o_C);
            end
            tick();
        end
    endtask

    task automatic test_rst_midjob();
        int k;
        int dones = 0;
        bus.i_A = fill(16'hFFFF); bus.i_B = fill(16'hFFFF);
        start_job(1'b0);
        wait_done(k);
        tick();
        bus.i_A = fill(16'hFFFF); bus.i_B = fill(16'hFFFF);
        start_job(1'b1);
        tick(); tick(); tick();
        rst = 1'b1;
        #1;
        vectors++;
        if (bus.o_busy !== 1'b0 || bus.o_C !== '0 || bus.o_ovf !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_mid busy=%b ovf=%b C=%h want 0 0 0", bus.o_busy, bus.o_ovf, bus.o_C);
        end
        tick(); tick();
        rst = 1'b0;
        for (int n = 0; n < 12; n++) begin
            tick();
            if (bus.o_done === 1'b1) dones++;
        end
        vectors++;
        if (dones != 0 || bus.o_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_abandon dones=%0d busy=%b want 0 0", dones, bus.o_busy);
        end
        bus.i_A = fill(16'h0f0f); bus.i_B = fill(16'h0f0f);
        start_job(1'b0);
        wait_done(k);
        vectors++;
        if (k != 8) begin
            miscompares++;
            $display("FAIL rst_rerun_latency got %0d want 8", k);
        end
        for (int e = 0; e < NE; e++) begin
            vectors++;
            if (bus.o_C[e*ACC_W +: ACC_W] !== 34'h02A848A3) begin
                miscompares++;
                $display("FAIL rst_rerun_C[%0d] got %h want 02a848a3", e, bus.o_C[e*ACC_W +: ACC_W]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_overwrite();
        test_identity();
        test_overflow();
        test_stall();
        test_clr_start();
        test_rst_midjob();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
